dmem_mmio: RTL
==============

DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, is the number of 32-bit data RAM words and SHALL be a power of two.
REQ-002 Parameter FIFO_DEPTH, default 4, is the number of console TX FIFO entries and SHALL be a power of two, 2 or greater.
REQ-003 clk  input  1  is the single clock; all state SHALL change only on its rising edge.
REQ-004 reset_n  input  1  is the reset: synchronous and active-low.
REQ-005 daddr  input  32  is the byte address from the CPU data port.
REQ-006 dwdata  input  32  is the write data from the CPU data port.
REQ-007 dwe  input  4  is the per-byte-lane write enable; bit i qualifies dwdata[8i+7:8i].
REQ-008 drdata  output  32  is the read data to the CPU; it is combinational from daddr and current state.
REQ-009 tx_data  output  8  is the console FIFO head byte.
REQ-010 tx_valid  output  1  is high when the console FIFO is non-empty.
REQ-011 tx_ready  input  1  is the downstream console accept signal.

Function
REQ-012 Address map: daddr[31] = 0 selects RAM; 0x8000_0000 is TXDATA, 0x8000_0004 is STATUS, 0x8000_0008 is CYCLE; all other addresses SHALL read 0 and ignore writes.
REQ-013 RAM word index SHALL be daddr[log2(DEPTH_WORDS)+1:2]; higher RAM address bits are ignored, so addresses alias (wrap).
REQ-014 RAM reads SHALL be asynchronous. A same-cycle write SHALL return the old word on drdata and the new word from the next cycle.
REQ-015 RAM writes SHALL update only the byte lanes with dwe[i] = 1, at the rising edge.
REQ-016 A TXDATA write with dwe[0] = 1 SHALL push dwdata[7:0]; TXDATA reads SHALL return 0.
REQ-017 A push while the FIFO is full and no pop occurs SHALL be dropped and SHALL set the sticky overflow bit.
REQ-018 A pop SHALL occur at a rising edge when tx_valid and tx_ready are both high; tx_data SHALL present the oldest entry.
REQ-019 Simultaneous push and pop SHALL be handled as follows:
- Both are accepted and the occupancy count is unchanged.
- This includes the full case, where the push is not dropped.
REQ-020 Empty FIFO: there is no bypass; a pushed byte SHALL appear on tx_valid/tx_data on the cycle after the push edge.
REQ-021 STATUS read SHALL return {29'b0, overflow, full, empty}.
REQ-022 A STATUS write with any dwe bit set and dwdata[2] = 1 SHALL clear overflow. If a dropped push would set overflow in the same cycle, clear SHALL win.
REQ-023 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be derived from an occupancy count of width log2(FIFO_DEPTH)+1.
REQ-024 The CYCLE counter SHALL increment by 1 every cycle and wrap from 0xFFFF_FFFF to 0.
REQ-025 A CYCLE write with dwe = 4'hF SHALL load dwdata at that edge, taking priority over the increment; partial-lane CYCLE writes SHALL be ignored.
REQ-026 While reset_n = 0, drdata and tx_valid SHALL be driven 0 and all writes and pops SHALL be ignored.

Reset
REQ-027 On a rising edge with reset_n = 0, the block SHALL:
- empty the FIFO, zeroing both pointers and the count;
- clear overflow;
- set CYCLE to 0.
REQ-028 RAM contents and FIFO storage SHALL NOT be reset.
REQ-029 Reset mid-transfer SHALL discard all queued bytes, with tx_valid = 0 on the following cycle.

Configuration
REQ-030 With macro DMEM_MMIO_CYCLE_CSR_EN defined, the CYCLE counter SHALL be present as specified.
REQ-031 Without DMEM_MMIO_CYCLE_CSR_EN:
- no counter flops SHALL be synthesized;
- CYCLE reads SHALL return 0;
- CYCLE writes SHALL be ignored.

Verification
REQ-032 Byte-lane write: write 0x1122_3344 to 0x10 with dwe = 4'hF, then 0x0000_AA00 with dwe = 4'b0010 -> a read of 0x10 returns 0x1122_AA44.
REQ-033 Aliasing: with DEPTH_WORDS = 1024, write 0xDEAD_BEEF to 0x0000_0004 -> a read of 0x0000_1004 returns 0xDEAD_BEEF.
REQ-034 FIFO fill with tx_ready = 0:
- Push 0x41 through 0x45 (5 pushes) -> STATUS = 0x6 (overflow, full).
- Then, with tx_ready = 1, tx_data sequence is 0x41, 0x42, 0x43, 0x44, and STATUS ends at 0x5.
- A STATUS write of 0x4 then reads back 0x1.
REQ-035 Full FIFO, tx_ready = 1, push 0x55 in the same cycle -> overflow stays 0, count stays 4, and 0x55 emerges last.
REQ-036 CYCLE (macro defined):
- Write 0xFFFF_FFFE -> reads show 0xFFFF_FFFF, 0x0000_0000 on the following cycles.
- dwe = 4'h1 write -> ignored.
- Macro undefined -> reads return 0.
REQ-037 Reset mid-operation: with 3 bytes queued, assert reset_n = 0 for 1 cycle -> tx_valid = 0, STATUS = 0x1, and RAM data written before reset is still readable.

Source files
------------

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data RAM with console TX FIFO, STATUS and CYCLE MMIO registers
// Optional CYCLE counter is built only when DMEM_MMIO_CYCLE_CSR_EN is defined.
module dmem_mmio #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  dwe,
   output logic [31:0] drdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);
   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned FW = $clog2(FIFO_DEPTH);
   localparam logic [FW:0]   CNT_FULL = (FW+1)'(FIFO_DEPTH);
   localparam logic [FW:0]   CNT_ONE  = (FW+1)'(1);
   localparam logic [FW-1:0] PTR_ONE  = FW'(1);

   localparam logic [31:0] ADDR_TXDATA = 32'h8000_0000;
   localparam logic [31:0] ADDR_STATUS = 32'h8000_0004;
   localparam logic [31:0] ADDR_CYCLE  = 32'h8000_0008;

   logic          sel_ram;
   logic          sel_tx;
   logic          sel_status;
   logic          sel_cycle;
   logic [AW-1:0] ram_idx;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [FW-1:0] rd_ptr;
   logic [FW-1:0] wr_ptr;
   logic [FW:0]   count;
   logic          overflow;
   logic          full;
   logic          empty;
   logic          push_req;
   logic          push;
   logic          pop;
   logic          drop;
   logic          ovf_clear;
   logic [31:0]   cycle_rd;

   assign sel_ram    = ~daddr[31];
   assign sel_tx     = (daddr == ADDR_TXDATA);
   assign sel_status = (daddr == ADDR_STATUS);
   assign sel_cycle  = (daddr == ADDR_CYCLE);
   assign ram_idx    = daddr[AW+1:2];

   assign full     = (count == CNT_FULL);
   assign empty    = (count == '0);
   assign tx_valid = reset_n & ~empty;
   assign tx_data  = fifo_mem[rd_ptr];

   // A pop in the same edge frees a slot, so a push into a full FIFO is kept.
   assign pop       = tx_valid & tx_ready;
   assign push_req  = reset_n & sel_tx & dwe[0];
   assign push      = push_req & (~full | pop);
   assign drop      = push_req & full & ~pop;
   assign ovf_clear = reset_n & sel_status & (|dwe) & dwdata[2];

   always_ff @(posedge clk) begin
      if (reset_n && sel_ram) begin
         for (int i = 0; i < 4; i++) begin
            if (dwe[i]) mem[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= dwdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      count <= count + CNT_ONE;
         else if (pop && !push) count <= count - CNT_ONE;
         if (ovf_clear)  overflow <= 1'b0;
         else if (drop)  overflow <= 1'b1;
      end
   end

`ifdef DMEM_MMIO_CYCLE_CSR_EN
   logic [31:0] cycle_q;

   always_ff @(posedge clk) begin
      if (!reset_n)                        cycle_q <= '0;
      else if (sel_cycle && dwe == 4'hF)   cycle_q <= dwdata;
      else                                 cycle_q <= cycle_q + 32'd1;
   end

   assign cycle_rd = cycle_q;
`else
   assign cycle_rd = '0;
`endif

   always_comb begin
      drdata = '0;
      if (reset_n) begin
         if (sel_ram)         drdata = mem[ram_idx];
         else if (sel_status) drdata = {29'b0, overflow, full, empty};
         else if (sel_cycle)  drdata = cycle_rd;
      end
   end

endmodule
